booth_mult: RTL and testbench

Sequential signed 32x32 multiplier for the multicycle datapath, used for MULT. It is the counterpart to the restoring divider. It computes the 64-bit two's-complement product with radix-2 Booth, one iteration per clock. It writes the upper word to HI_Out and the lower word to LO_Out for the HI/LO registers, and pulses Mult_Done for the control unit.

---
 rtl/math_pkg.sv | 29 ++
 rtl/booth_step.sv | 36 +++
 rtl/booth_mult.sv | 104 ++++++++++
 tb/tb_booth_mult.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared types and defaults for the sequential multiply datapath:
// FSM state encoding, Booth recoding ops and the pair-to-op decode.
package math_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  // Operands are loaded on the IDLE->RUN edge, so no separate LOAD state exists.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into ACC, then an arithmetic right shift of {ACC, Q, Q_1}.
module booth_step
  import math_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  booth_op_t        w_op;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;

  assign w_op    = booth_decode(i_q[0], i_q_1);
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = i_acc;
    case (w_op)
      OP_ADD:  w_sum = i_acc + w_m_ext;
      OP_SUB:  w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
  end

  // The extra ACC bit keeps the sign correct even for M = -2^(WIDTH-1).
  assign {o_acc, o_q, o_q_1} = {w_sum[WIDTH], w_sum, i_q};

endmodule

// File: rtl/booth_mult.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock.
// Product lands in HI_Out/LO_Out with a one-cycle Mult_Done pulse.
module booth_mult
  import math_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Mult_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Mult_Busy,
  output logic             Mult_Done,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out
);

  mult_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q_1;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_q_1 (w_q_1_nxt)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A low request level re-arms at any time, including mid-operation.
      if (!Mult_Control) r_armed <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_armed && Mult_Control) begin
            r_armed <= 1'b0;
            r_m     <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_q_1 <= w_q_1_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Busy covers the LOAD/RUN span only; the DONE cycle reads as idle.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_hi    <= r_acc[WIDTH-1:0];
          r_lo    <= r_q;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Mult_Busy = r_busy;
  assign Mult_Done = r_done;
  assign HI_Out    = r_hi;
  assign LO_Out    = r_lo;

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult: a timeline model of the signed product
// is compared against the outputs every cycle, plus literal product checks.
module tb_booth_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  booth_mult dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .Mult_Control (ctrl),
    .A            (a_in),
    .B            (b_in),
    .Mult_Busy    (busy),
    .Mult_Done    (done),
    .HI_Out       (hi),
    .LO_Out       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase counts edges since the accepting edge (-1 when idle).
  // Product computed with plain 64-bit signed arithmetic.
  int          phase = -1;
  bit          m_armed = 1'b0;
  longint      pending = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  bit          exp_busy = 1'b0, exp_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = -1; m_armed = 1'b0;
      exp_hi = '0; exp_lo = '0;
    end else begin
      if ((phase < 0 || phase == 33) && m_armed && ctrl) begin
        pending = longint'($signed(a_in)) * longint'($signed(b_in));
        phase = 0;
        m_armed = 1'b0;
      end else if (phase >= 0 && phase < 33) begin
        phase++;
        if (phase == 33) {exp_hi, exp_lo} = pending;
      end else begin
        phase = -1;
      end
      if (!ctrl) m_armed = 1'b1;
    end
    exp_busy = (phase >= 0 && phase <= 31);
    exp_done = (phase == 33);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("hi", 64'(hi), 64'(exp_hi));
      check("lo", 64'(lo), 64'(exp_lo));
    end
  end

  // Pulse the request for one cycle and track latency, busy span and results.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want_hi, input logic [31:0] want_lo,
                        input bit scramble);
    int k, busy_cnt;
    @(negedge clk);
    ctrl = 1'b0;
    @(negedge clk);
    ctrl = 1'b1; a_in = a; b_in = b;
    k = 0; busy_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (scramble) begin a_in = $urandom; b_in = $urandom; end
      if (busy) busy_cnt++;
      if (done) begin k = i; break; end
    end
    if (k == 0) k = 61;
    check({name, "_latency"}, 64'(k - 1), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({name, "_hi"}, 64'(hi), 64'(want_hi));
    check({name, "_lo"}, 64'(lo), 64'(want_lo));
    $display("op %s: A=0x%08h B=0x%08h -> HI=0x%08h LO=0x%08h", name, a, b, hi, lo);
  endtask

  initial begin
    int dcnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op("6x2", 32'd6, 32'd2, 32'h0000_0000, 32'h0000_000C, 1'b0);
    run_op("m3x7", 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("maxxm1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);

    // Abort: reset sampled on the 10th RUN edge.
    @(negedge clk);
    ctrl = 1'b1; a_in = 32'd5; b_in = 32'd5;
    dcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (done) dcnt++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    $display("op abort: reset mid-run, HI=0x%08h LO=0x%08h", hi, lo);
    run_op("5x5", 32'd5, 32'd5, 32'h0000_0000, 32'h0000_0019, 1'b0);

    // Level held high runs exactly once; a one-cycle drop re-arms.
    @(negedge clk);
    ctrl = 1'b1; a_in = 32'd3; b_in = 32'hFFFF_FFFC;
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("hold_one_done", 64'(dcnt), 64'd1);
    check("hold_hi", 64'(hi), 64'hFFFF_FFFF);
    check("hold_lo", 64'(lo), 64'hFFFF_FFF4);
    $display("op hold: dones=%0d HI=0x%08h LO=0x%08h", dcnt, hi, lo);
    ctrl = 1'b0;
    @(negedge clk);
    ctrl = 1'b1; a_in = 32'd9; b_in = 32'd9;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    ctrl = 1'b0;
    check("rearm_done", 64'(dcnt), 64'd1);
    check("rearm_lo", 64'(lo), 64'd81);
    $display("op rearm: dones=%0d HI=0x%08h LO=0x%08h", dcnt, hi, lo);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
